// File: rtl/lsu_mem_arbiter_pkg.sv
// Shared types for the LSU-to-memory arbiter: channel FSM states and index sizing.
package lsu_mem_arbiter_pkg;

    typedef enum logic [2:0] {
        CH_IDLE        = 3'd0,
        CH_READ_WAIT   = 3'd1,
        CH_WRITE_WAIT  = 3'd2,
        CH_READ_RELAY  = 3'd3,
        CH_WRITE_RELAY = 3'd4
    } ch_state_t;

    // Index width for n items; a single item still needs a 1-bit index.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lsu_mem_arbiter_rr.sv
// Round-robin search: first requester at or after start (wrapping) that is not excluded.
module lsu_rr_picker
    import lsu_mem_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_bits(N)
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  excl,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [IW:0] pos;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, start} + (IW+1)'(k);
            if (pos >= (IW+1)'(N))
                pos = pos - (IW+1)'(N);
            if (!found && req[pos[IW-1:0]] && !excl[pos[IW-1:0]]) begin
                found = 1'b1;
                idx   = pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/lsu_mem_arbiter.sv
// Multiplexes per-thread LSU read/write requests onto NUM_CHANNELS memory channels,
// each channel serving one consumer at a time and picking consumers round-robin.
module lsu_mem_arbiter
    import lsu_mem_arbiter_pkg::*;
#(
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]                  mem_read_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_read_address,
    input  logic [NUM_CHANNELS-1:0]                  mem_read_ready,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_read_data,
    output logic [NUM_CHANNELS-1:0]                  mem_write_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_write_address,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_write_data,
    input  logic [NUM_CHANNELS-1:0]                  mem_write_ready
);

    localparam int IW = idx_bits(NUM_CONSUMERS);

    ch_state_t                                 state [NUM_CHANNELS];
    logic [IW-1:0]                             cur   [NUM_CHANNELS];
    logic [IW-1:0]                             rr    [NUM_CHANNELS];
    logic [IW-1:0]                             pick  [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0]                  claimed;
    logic [NUM_CONSUMERS-1:0]                  req;
    logic [NUM_CHANNELS-1:0][NUM_CONSUMERS-1:0] excl;
    logic [NUM_CHANNELS-1:0]                   found;
    logic [NUM_CHANNELS-1:0]                   win;

    assign req     = consumer_read_valid | consumer_write_valid;
    assign excl[0] = claimed;

    // Lower-indexed channels pick first; each pick is excluded from higher channels this cycle.
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        lsu_rr_picker #(.N(NUM_CONSUMERS), .IW(IW)) u_pick (
            .req   (req),
            .excl  (excl[c]),
            .start (rr[c]),
            .found (found[c]),
            .idx   (pick[c])
        );
        assign win[c] = found[c] && (state[c] == CH_IDLE);
        if (c + 1 < NUM_CHANNELS) begin : g_chain
            assign excl[c+1] = excl[c] | (win[c] ? (NUM_CONSUMERS'(1) << pick[c]) : '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state[c] <= CH_IDLE;
                cur[c]   <= '0;
                rr[c]    <= '0;
            end
            claimed              <= '0;
            consumer_read_ready  <= '0;
            consumer_read_data   <= '0;
            consumer_write_ready <= '0;
            mem_read_valid       <= '0;
            mem_read_address     <= '0;
            mem_write_valid      <= '0;
            mem_write_address    <= '0;
            mem_write_data       <= '0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                case (state[c])
                    CH_IDLE: if (win[c]) begin
                        claimed[pick[c]] <= 1'b1;
                        cur[c]           <= pick[c];
                        rr[c]            <= (pick[c] == IW'(NUM_CONSUMERS-1)) ? '0 : pick[c] + 1'b1;
                        if (consumer_read_valid[pick[c]]) begin
                            mem_read_valid[c]   <= 1'b1;
                            mem_read_address[c] <= consumer_read_address[pick[c]];
                            state[c]            <= CH_READ_WAIT;
                        end else begin
                            mem_write_valid[c]   <= 1'b1;
                            mem_write_address[c] <= consumer_write_address[pick[c]];
                            mem_write_data[c]    <= consumer_write_data[pick[c]];
                            state[c]             <= CH_WRITE_WAIT;
                        end
                    end
                    CH_READ_WAIT: if (mem_read_ready[c]) begin
                        mem_read_valid[c]           <= 1'b0;
                        consumer_read_ready[cur[c]] <= 1'b1;
                        consumer_read_data[cur[c]]  <= mem_read_data[c];
                        state[c]                    <= CH_READ_RELAY;
                    end
                    CH_WRITE_WAIT: if (mem_write_ready[c]) begin
                        mem_write_valid[c]           <= 1'b0;
                        consumer_write_ready[cur[c]] <= 1'b1;
                        state[c]                     <= CH_WRITE_RELAY;
                    end
                    CH_READ_RELAY: if (!consumer_read_valid[cur[c]]) begin
                        consumer_read_ready[cur[c]] <= 1'b0;
                        claimed[cur[c]]             <= 1'b0;
                        state[c]                    <= CH_IDLE;
                    end
                    CH_WRITE_RELAY: if (!consumer_write_valid[cur[c]]) begin
                        consumer_write_ready[cur[c]] <= 1'b0;
                        claimed[cur[c]]              <= 1'b0;
                        state[c]                     <= CH_IDLE;
                    end
                    default: state[c] <= CH_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Directed bench: one single-channel arbiter (dut_a) and one two-channel arbiter (dut_b).
module tb_lsu_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // single-channel instance
    logic [3:0]       a_crv, a_crr, a_cwv, a_cwr;
    logic [3:0][7:0]  a_cra, a_crd, a_cwa, a_cwd;
    logic [0:0]       a_mrv, a_mrr, a_mwv, a_mwr;
    logic [0:0][7:0]  a_mra, a_mrd, a_mwa, a_mwd;

    // two-channel instance
    logic [3:0]       b_crv, b_crr, b_cwv, b_cwr;
    logic [3:0][7:0]  b_cra, b_crd, b_cwa, b_cwd;
    logic [1:0]       b_mrv, b_mrr, b_mwv, b_mwr;
    logic [1:0][7:0]  b_mra, b_mrd, b_mwa, b_mwd;

    int checks = 0;
    int errors = 0;

    lsu_mem_arbiter #(.NUM_CONSUMERS(4), .NUM_CHANNELS(1), .ADDR_BITS(8), .DATA_BITS(8)) dut_a (
        .clk(clk), .reset(rst_n),
        .consumer_read_valid(a_crv), .consumer_read_address(a_cra),
        .consumer_read_ready(a_crr), .consumer_read_data(a_crd),
        .consumer_write_valid(a_cwv), .consumer_write_address(a_cwa),
        .consumer_write_data(a_cwd), .consumer_write_ready(a_cwr),
        .mem_read_valid(a_mrv), .mem_read_address(a_mra),
        .mem_read_ready(a_mrr), .mem_read_data(a_mrd),
        .mem_write_valid(a_mwv), .mem_write_address(a_mwa),
        .mem_write_data(a_mwd), .mem_write_ready(a_mwr)
    );

    lsu_mem_arbiter #(.NUM_CONSUMERS(4), .NUM_CHANNELS(2), .ADDR_BITS(8), .DATA_BITS(8)) dut_b (
        .clk(clk), .reset(rst_n),
        .consumer_read_valid(b_crv), .consumer_read_address(b_cra),
        .consumer_read_ready(b_crr), .consumer_read_data(b_crd),
        .consumer_write_valid(b_cwv), .consumer_write_address(b_cwa),
        .consumer_write_data(b_cwd), .consumer_write_ready(b_cwr),
        .mem_read_valid(b_mrv), .mem_read_address(b_mra),
        .mem_read_ready(b_mrr), .mem_read_data(b_mrd),
        .mem_write_valid(b_mwv), .mem_write_address(b_mwa),
        .mem_write_data(b_mwd), .mem_write_ready(b_mwr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int order [5] = '{0, 1, 2, 3, 0};

    initial begin
        a_crv = '0; a_cra = '0; a_cwv = '0; a_cwa = '0; a_cwd = '0;
        a_mrr = '0; a_mrd = '0; a_mwr = '0;
        b_crv = '0; b_cra = '0; b_cwv = '0; b_cwa = '0; b_cwd = '0;
        b_mrr = '0; b_mrd = '0; b_mwr = '0;

        // reset state
        #3;
        chk("rst_mrv", 32'(a_mrv), 32'h0);
        chk("rst_crr", 32'(a_crr), 32'h0);
        chk("rst_cwr", 32'(a_cwr), 32'h0);
        chk("rst_mwv", 32'(a_mwv), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // single read: consumer 2, addr 0x3C, data 0xA5 after 2 cycles
        a_crv[2] = 1'b1; a_cra[2] = 8'h3C;
        tick();
        chk("rd_mrv", 32'(a_mrv), 32'h1);
        chk("rd_mra", 32'(a_mra[0]), 32'h3C);
        chk("rd_crr_early", 32'(a_crr), 32'h0);
        a_cra[2] = 8'hFF;
        tick();
        chk("rd_mra_held", 32'(a_mra[0]), 32'h3C);
        a_mrr[0] = 1'b1; a_mrd[0] = 8'hA5;
        tick();
        chk("rd_crr", 32'(a_crr), 32'h4);
        chk("rd_crd", 32'(a_crd[2]), 32'hA5);
        chk("rd_mrv_drop", 32'(a_mrv), 32'h0);
        a_mrr[0] = 1'b0; a_mrd[0] = 8'h00;
        tick();
        chk("rd_relay_hold", 32'(a_crr), 32'h4);
        a_crv[2] = 1'b0;
        tick();
        chk("rd_crr_drop", 32'(a_crr), 32'h0);
        chk("rd_crd_hold", 32'(a_crd[2]), 32'hA5);

        // single write: consumer 1 writes 0x7E to 0x10
        a_cwv[1] = 1'b1; a_cwa[1] = 8'h10; a_cwd[1] = 8'h7E;
        tick();
        chk("wr_mwv", 32'(a_mwv), 32'h1);
        chk("wr_mwa", 32'(a_mwa[0]), 32'h10);
        chk("wr_mwd", 32'(a_mwd[0]), 32'h7E);
        tick();
        chk("wr_cwr_early", 32'(a_cwr), 32'h0);
        a_mwr[0] = 1'b1;
        tick();
        chk("wr_cwr", 32'(a_cwr), 32'h2);
        chk("wr_mwv_drop", 32'(a_mwv), 32'h0);
        a_mwr[0] = 1'b0;
        tick();
        chk("wr_cwr_hold", 32'(a_cwr), 32'h2);
        a_cwv[1] = 1'b0;
        tick();
        chk("wr_cwr_drop", 32'(a_cwr), 32'h0);

        // reset while in CH_READ_WAIT, asserted between clock edges
        a_crv[0] = 1'b1; a_cra[0] = 8'h55;
        tick();
        chk("mid_mrv_pre", 32'(a_mrv), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_mrv", 32'(a_mrv), 32'h0);
        chk("mid_mra", 32'(a_mra[0]), 32'h0);
        chk("mid_crd", 32'(a_crd), 32'h0);
        a_crv[0] = 1'b0;
        tick();
        rst_n = 1'b1;
        a_crv[3] = 1'b1; a_cra[3] = 8'h77;
        tick();
        chk("post_mrv", 32'(a_mrv), 32'h1);
        chk("post_mra", 32'(a_mra[0]), 32'h77);
        a_mrr[0] = 1'b1; a_mrd[0] = 8'h3C;
        tick();
        chk("post_crr", 32'(a_crr), 32'h8);
        chk("post_crd", 32'(a_crd[3]), 32'h3C);
        a_mrr[0] = 1'b0; a_crv[3] = 1'b0;
        tick();

        // round-robin: all four read, consumer 0 re-requests while 1 is served
        for (int i = 0; i < 4; i++) a_cra[i] = 8'(8'h40 + i);
        a_crv = 4'hF;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("rr%0d_mrv", k), 32'(a_mrv), 32'h1);
            chk($sformatf("rr%0d_mra", k), 32'(a_mra[0]), 32'(8'h40 + order[k]));
            if (k == 1) a_crv[0] = 1'b1;
            a_mrr[0] = 1'b1; a_mrd[0] = 8'(8'h90 + order[k]);
            tick();
            chk($sformatf("rr%0d_crr", k), 32'(a_crr), 32'(4'b1 << order[k]));
            chk($sformatf("rr%0d_crd", k), 32'(a_crd[order[k]]), 32'(8'h90 + order[k]));
            a_mrr[0] = 1'b0;
            a_crv[order[k]] = 1'b0;
            tick();
            chk($sformatf("rr%0d_drop", k), 32'(a_crr), 32'h0);
        end

        // zero-latency memory: ready tied high
        a_mrr[0] = 1'b1; a_mrd[0] = 8'h5A;
        a_crv[1] = 1'b1; a_cra[1] = 8'h21;
        tick();
        chk("zl_mrv", 32'(a_mrv), 32'h1);
        chk("zl_mra", 32'(a_mra[0]), 32'h21);
        chk("zl_crr_early", 32'(a_crr), 32'h0);
        tick();
        chk("zl_crr", 32'(a_crr), 32'h2);
        chk("zl_crd", 32'(a_crd[1]), 32'h5A);
        chk("zl_mrv_drop", 32'(a_mrv), 32'h0);
        a_crv[1] = 1'b0;
        tick();
        chk("zl_crr_drop", 32'(a_crr), 32'h0);
        a_mrr[0] = 1'b0;

        // two channels, four simultaneous readers
        for (int i = 0; i < 4; i++) b_cra[i] = 8'(8'h40 + i);
        b_crv = 4'hF;
        tick();
        chk("dual_mrv", 32'(b_mrv), 32'h3);
        chk("dual_mra0", 32'(b_mra[0]), 32'h40);
        chk("dual_mra1", 32'(b_mra[1]), 32'h41);
        b_mrr = 2'b11; b_mrd[0] = 8'hC0; b_mrd[1] = 8'hC1;
        tick();
        chk("dual_crr", 32'(b_crr), 32'h3);
        chk("dual_crd0", 32'(b_crd[0]), 32'hC0);
        chk("dual_crd1", 32'(b_crd[1]), 32'hC1);
        b_mrr = 2'b00;
        b_crv[0] = 1'b0; b_crv[1] = 1'b0;
        tick();
        chk("dual_drop", 32'(b_crr), 32'h0);
        tick();
        chk("dual2_mrv", 32'(b_mrv), 32'h3);
        chk("dual2_mra0", 32'(b_mra[0]), 32'h42);
        chk("dual2_mra1", 32'(b_mra[1]), 32'h43);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
